// File: rtl/apb_reg_bank.sv
// apb_reg_bank: parametrised APB4 slave register bank with per-byte strobes,
// read-only registers fed from reg_d_i, fixed wait states and PSLVERR on
// illegal accesses. Register contents and per-register write/read pulses are
// exported to the attached core.
// Optional feature: define APB_REG_BANK_PROT_CHECK_EN to reject unprivileged
// accesses (pprot_i[0]=0) with PSLVERR; by default pprot_i is ignored.
module apb_reg_bank #(
  parameter int g_apb_addr_width = 32,
  parameter int g_apb_data_width = 32,
  parameter int g_num_regs       = 8,
  parameter int g_wait_states    = 0,
  parameter logic [g_num_regs-1:0]                  g_ro_mask   = '0,
  parameter logic [g_num_regs*g_apb_data_width-1:0] g_reset_val = '0
) (
  input  logic                                   pclk_i,
  input  logic                                   preset_n_i,
  input  logic [g_apb_addr_width-1:0]            paddr_i,
  input  logic [2:0]                             pprot_i,
  input  logic                                   psel_i,
  input  logic                                   penable_i,
  input  logic                                   pwrite_i,
  input  logic [g_apb_data_width-1:0]            pwdata_i,
  input  logic [g_apb_data_width/8-1:0]          pstrb_i,
  output logic                                   pready_o,
  output logic [g_apb_data_width-1:0]            prdata_o,
  output logic                                   pslverr_o,
  output logic [g_num_regs*g_apb_data_width-1:0] reg_q_o,
  input  logic [g_num_regs*g_apb_data_width-1:0] reg_d_i,
  output logic [g_num_regs-1:0]                  reg_wr_pulse_o,
  output logic [g_num_regs-1:0]                  reg_rd_pulse_o
);

  localparam int AW     = g_apb_addr_width;
  localparam int W      = g_apb_data_width;
  localparam int SW     = W / 8;
  localparam int OFF_W  = $clog2(SW);
  localparam int REGS_W = g_num_regs * W;

  // Byte-offset bits that must be zero for a word-aligned access.
  localparam logic [AW-1:0] ALIGN_MASK = AW'(SW - 1);
  localparam logic [AW-1:0] NUM_REGS_A = AW'(g_num_regs);
  localparam logic [3:0]    WS_LOAD    = 4'(g_wait_states);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                write_q, write_d;
  logic [W-1:0]        wdata_q, wdata_d;
  logic [SW-1:0]       strb_q, strb_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [W-1:0]        prdata_q, prdata_d;
  logic [g_num_regs-1:0] wr_pulse_q, wr_pulse_d;
  logic [g_num_regs-1:0] rd_pulse_q, rd_pulse_d;
  logic [REGS_W-1:0]   regs_q, regs_d;

  logic [AW-1:0]         word;
  logic                  addr_bad;
  logic [g_num_regs-1:0] idx_hit;
  logic                  is_ro;
  logic [W-1:0]          rd_val;
  logic                  err;
  logic                  capture;

`ifdef APB_REG_BANK_PROT_CHECK_EN
  logic prot_q, prot_d;
  logic unused_prot;
  assign unused_prot = ^pprot_i[2:1];
`else
  logic unused_prot;
  assign unused_prot = ^pprot_i;
`endif

  // Decode the captured address into a one-hot register hit, legality,
  // read-only status and the value a read would return.
  always_comb begin
    word     = addr_q >> OFF_W;
    addr_bad = ((addr_q & ALIGN_MASK) != '0) || (word >= NUM_REGS_A);
    idx_hit  = '0;
    is_ro    = 1'b0;
    rd_val   = '0;
    for (int i = 0; i < g_num_regs; i++) begin
      if (word == AW'(i)) begin
        idx_hit[i] = 1'b1;
        is_ro      = g_ro_mask[i];
        rd_val     = g_ro_mask[i] ? reg_d_i[i*W +: W] : regs_q[i*W +: W];
      end
    end
    err = addr_bad | (write_q & is_ro);
`ifdef APB_REG_BANK_PROT_CHECK_EN
    err = err | ~prot_q;
`endif
  end

  // Transfer FSM: capture on setup, count wait states, then complete with a
  // one-cycle response and commit the write or return read data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
`ifdef APB_REG_BANK_PROT_CHECK_EN
    prot_d     = prot_q;
`endif
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    wr_pulse_d = '0;
    rd_pulse_d = '0;
    regs_d     = regs_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        capture = psel_i & ~penable_i;
      end
      ACCESS: begin
        if (!psel_i) begin
          // Master abandoned the transfer: drop it without side effects.
          state_d = IDLE;
        end else if (penable_i) begin
          if (cnt_q == 4'd0) begin
            state_d  = DONE;
            pready_d = 1'b1;
            if (err) begin
              pslverr_d = 1'b1;
            end else if (write_q) begin
              wr_pulse_d = idx_hit;
              for (int i = 0; i < g_num_regs; i++) begin
                for (int k = 0; k < SW; k++) begin
                  if (idx_hit[i] && strb_q[k]) begin
                    regs_d[i*W + k*8 +: 8] = wdata_q[k*8 +: 8];
                  end
                end
              end
            end else begin
              prdata_d   = rd_val;
              rd_pulse_d = idx_hit;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        capture = psel_i & ~penable_i;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      state_d = ACCESS;
      cnt_d   = WS_LOAD;
      addr_d  = paddr_i;
      write_d = pwrite_i;
      wdata_d = pwdata_i;
      strb_d  = pstrb_i;
`ifdef APB_REG_BANK_PROT_CHECK_EN
      prot_d  = pprot_i[0];
`endif
    end
  end

  // State, response and register storage; everything returns to its reset
  // image asynchronously.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
`ifdef APB_REG_BANK_PROT_CHECK_EN
      prot_q     <= 1'b0;
`endif
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      regs_q     <= g_reset_val;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
`ifdef APB_REG_BANK_PROT_CHECK_EN
      prot_q     <= prot_d;
`endif
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign pready_o       = pready_q;
  assign pslverr_o      = pslverr_q;
  assign prdata_o       = prdata_q;
  assign reg_q_o        = regs_q;
  assign reg_wr_pulse_o = wr_pulse_q;
  assign reg_rd_pulse_o = rd_pulse_q;

endmodule
